alu_out_stage: RTL and testbench
================================

ALU_OUT_STAGE -- requirements
Module: alu_out_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of ALU result.
REQ-002 Parameter CNT_W, default 8, width of zero-result counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream ALU result valid.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_result  input  WIDTH  ALU result word.
REQ-008 in_zero  input  1  zero flag from ALU.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  downstream accepts head entry.
REQ-011 out_result  output  WIDTH  head entry result.
REQ-012 out_zero  output  1  head entry zero flag, as captured.
REQ-013 out_neg  output  1  head entry result MSB.
REQ-014 zero_cnt  output  CNT_W  count of accepted entries with in_zero=1.
REQ-015 zc_clr  input  1  synchronous clear of zero_cnt.
REQ-016 flag_err  output  1  sticky: captured in_zero disagreed with (in_result==0).

Function
REQ-017 Block SHALL be a 2-entry in-order FIFO (skid buffer) of {result, zero}; occupancy count 0..2.
REQ-018 Push SHALL occur on an edge where in_valid && in_ready; pop where out_valid && out_ready.
REQ-019 in_ready SHALL equal (count != 2), derived from registered state only; no combinational path from out_ready.
REQ-020 out_valid SHALL equal (count != 0).
REQ-021 Latency: entry pushed at edge N SHALL be presented on out_* in cycle after edge N when FIFO was empty (1-cycle latency); no same-cycle in->out passthrough.
REQ-022 Simultaneous push and pop at count 1 SHALL leave count 1 with new entry at head after edge.
REQ-023 Simultaneous push and pop at count 0 is impossible (no pop when empty); push alone applies.
REQ-024 At count 2 no push SHALL occur (in_ready=0); pop alone reduces count to 1 and in_ready rises next cycle.
REQ-025 While out_valid && !out_ready, out_result, out_zero, out_neg SHALL remain stable.
REQ-026 out_neg SHALL equal out_result[WIDTH-1]; out_* SHALL be 0 when count=0.
REQ-027 zero_cnt SHALL increment by 1 per push with in_zero=1, saturating at 2^CNT_W-1 (no wrap).
REQ-028 zc_clr=1 SHALL set zero_cnt to 0 at the edge, overriding a simultaneous increment.
REQ-029 flag_err SHALL set on any push where in_zero != (in_result==0) and hold until reset.
REQ-030 Internal pointers SHALL wrap modulo 2.

Reset
REQ-031 rst_n=0 SHALL immediately clear count, pointers, zero_cnt, flag_err; out_valid=0, out_result=0, out_zero=0, out_neg=0, in_ready=1.
REQ-032 Reset asserted mid-transfer SHALL discard all stored entries; no entry reappears after deassertion.
REQ-033 First push SHALL be possible on first rising edge after rst_n deasserts.

Verification
REQ-034 Push result=0x0 zero=1 (2&8), out_ready=1 -> next cycle out_valid=1, out_result=0, out_zero=1, zero_cnt=1, flag_err=0.
REQ-035 Push 0x8 zero=0 then 0x80000000 zero=0 with out_ready=0 -> in_ready=0 after 2nd push; head stays 0x8; out_neg=0; then out_ready=1 -> 0x8 then 0x80000000 with out_neg=1, in order.
REQ-036 Count=1, push 0x5 and pop same edge -> count stays 1, out_result=0x5 next cycle.
REQ-037 256 pushes of zero=1 with CNT_W=8 -> zero_cnt=255 holds; zc_clr with concurrent zero push -> zero_cnt=0.
REQ-038 Push result=0x8 with in_zero=1 -> flag_err=1, remains 1 after further good pushes until rst_n=0.
REQ-039 Fill to 2 entries, assert rst_n=0 asynchronously between edges -> out_valid=0, in_ready=1, zero_cnt=0 immediately; no stale data after release.

Source files
------------

// File: rtl/alu_out_stage_if.sv
// Handshake and status bundle between the ALU, the output stage and its consumer.
interface alu_out_stage_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_neg;
    logic [CNT_W-1:0] zero_cnt;
    logic             zc_clr;
    logic             flag_err;

    modport slave (
        input  in_valid, in_result, in_zero, out_ready, zc_clr,
        output in_ready, out_valid, out_result, out_zero, out_neg, zero_cnt, flag_err
    );

    modport master (
        output in_valid, in_result, in_zero, out_ready, zc_clr,
        input  in_ready, out_valid, out_result, out_zero, out_neg, zero_cnt, flag_err
    );
endinterface

// File: rtl/alu_out_stage.sv
// Two-entry skid buffer for ALU results with a saturating zero-result counter
// and a sticky flag for zero flags that disagree with the result word.
module alu_out_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_out_stage_if.slave       bus
);
    localparam logic [CNT_W-1:0] ZC_MAX = '1;

    logic [1:0][WIDTH-1:0] slot_result;
    logic [1:0]            slot_zero;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic [CNT_W-1:0]      zero_cnt;
    logic                  flag_err;

    logic                  ready;
    logic                  valid;
    logic                  push;
    logic                  pop;
    logic                  mismatch;
    logic [WIDTH-1:0]      head_result;
    logic                  head_zero;

    // Ready depends only on registered occupancy, so out_ready never reaches in_ready.
    assign ready    = (count != 2'd2);
    assign valid    = (count != 2'd0);
    assign push     = bus.in_valid && ready;
    assign pop      = valid && bus.out_ready;
    assign mismatch = bus.in_zero != (bus.in_result == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_result <= '0;
            slot_zero   <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                slot_result[wr_ptr] <= bus.in_result;
                slot_zero[wr_ptr]   <= bus.in_zero;
                wr_ptr              <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (!push && pop) begin
                count <= count - 2'd1;
            end
        end
    end

    // Clear wins over a same-edge increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt <= '0;
        end else if (bus.zc_clr) begin
            zero_cnt <= '0;
        end else if (push && bus.in_zero && (zero_cnt != ZC_MAX)) begin
            zero_cnt <= zero_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_err <= 1'b0;
        end else if (push && mismatch) begin
            flag_err <= 1'b1;
        end
    end

    assign head_result = valid ? slot_result[rd_ptr] : '0;
    assign head_zero   = valid ? slot_zero[rd_ptr]   : 1'b0;

    assign bus.in_ready   = ready;
    assign bus.out_valid  = valid;
    assign bus.out_result = head_result;
    assign bus.out_zero   = head_zero;
    assign bus.out_neg    = head_result[WIDTH-1];
    assign bus.zero_cnt   = zero_cnt;
    assign bus.flag_err   = flag_err;
endmodule

// File: tb/tb_alu_out_stage.sv
// Bench for alu_out_stage: directed scenarios with literal expectations, then
// random traffic checked every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_alu_out_stage;
    localparam int WIDTH  = 32;
    localparam int CNT_W  = 8;
    localparam int ZC_SAT = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
    } entry_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    entry_t q[$];
    int     m_zcnt = 0;
    bit     m_err  = 1'b0;

    alu_out_stage_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_out_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of accepted entries, advanced at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_zcnt = 0;
            m_err  = 1'b0;
        end else begin
            bit do_push;
            bit do_pop;
            entry_t e;
            do_push = bus.in_valid && (q.size() < 2);
            do_pop  = (q.size() > 0) && bus.out_ready;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.result = bus.in_result;
                e.zero   = bus.in_zero;
                q.push_back(e);
                if (bus.in_zero != (bus.in_result == 0)) m_err = 1'b1;
            end
            if (bus.zc_clr) m_zcnt = 0;
            else if (do_push && bus.in_zero && m_zcnt < ZC_SAT) m_zcnt = m_zcnt + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every falling edge: DUT outputs against the model.
    always @(negedge clk) begin
        logic [WIDTH-1:0] exp_result;
        logic             exp_zero;
        exp_result = (q.size() > 0) ? q[0].result : '0;
        exp_zero   = (q.size() > 0) ? q[0].zero   : 1'b0;
        check_output("model.in_ready",   32'(bus.in_ready),   32'(q.size() < 2));
        check_output("model.out_valid",  32'(bus.out_valid),  32'(q.size() > 0));
        check_output("model.out_result", bus.out_result,      exp_result);
        check_output("model.out_zero",   32'(bus.out_zero),   32'(exp_zero));
        check_output("model.out_neg",    32'(bus.out_neg),    32'(exp_result[WIDTH-1]));
        check_output("model.zero_cnt",   32'(bus.zero_cnt),   32'(m_zcnt));
        check_output("model.flag_err",   32'(bus.flag_err),   32'(m_err));
    end

    // Drive one cycle of inputs, then return 1 ns after the edge that consumes them.
    task automatic apply_stimulus(input bit v, input logic [WIDTH-1:0] r, input bit z,
                                  input bit ordy, input bit clr);
        bus.in_valid  = v;
        bus.in_result = r;
        bus.in_zero   = z;
        bus.out_ready = ordy;
        bus.zc_clr    = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_zero   = 1'b0;
        bus.out_ready = 1'b0;
        bus.zc_clr    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_output("rst.in_ready",   32'(bus.in_ready),  32'h1);
        check_output("rst.out_valid",  32'(bus.out_valid), 32'h0);
        check_output("rst.out_result", bus.out_result,     32'h0);
        check_output("rst.zero_cnt",   32'(bus.zero_cnt),  32'h0);
        rst_n = 1'b1;

        // First edge after release accepts a push; one-cycle latency to the head.
        apply_stimulus(1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
        check_output("lat.out_valid",  32'(bus.out_valid), 32'h1);
        check_output("lat.out_result", bus.out_result,     32'h0);
        check_output("lat.out_zero",   32'(bus.out_zero),  32'h1);
        check_output("lat.zero_cnt",   32'(bus.zero_cnt),  32'h1);
        check_output("lat.flag_err",   32'(bus.flag_err),  32'h0);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        apply_stimulus(1'b1, 32'h8, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        check_output("full.in_ready",  32'(bus.in_ready), 32'h0);
        check_output("full.head",      bus.out_result,    32'h8);
        check_output("full.out_neg",   32'(bus.out_neg),  32'h0);
        apply_stimulus(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
        check_output("stall.head",     bus.out_result,    32'h8);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_output("drain.head2",    bus.out_result,    32'h8000_0000);
        check_output("drain.out_neg",  32'(bus.out_neg),  32'h1);
        check_output("drain.in_ready", 32'(bus.in_ready), 32'h1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_output("drain.empty",    32'(bus.out_valid), 32'h0);

        apply_stimulus(1'b1, 32'h3, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h5, 1'b0, 1'b1, 1'b0);
        check_output("pp.head",        bus.out_result,    32'h5);
        check_output("pp.in_ready",    32'(bus.in_ready), 32'h1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        apply_stimulus(1'b1, 32'h8, 1'b1, 1'b1, 1'b0);
        check_output("err.set",        32'(bus.flag_err), 32'h1);
        apply_stimulus(1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'h7, 1'b0, 1'b1, 1'b0);
        check_output("err.sticky",     32'(bus.flag_err), 32'h1);

        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check_output("zc.clr",         32'(bus.zero_cnt), 32'h0);
        for (int i = 0; i < 256; i++) apply_stimulus(1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
        check_output("zc.sat",         32'(bus.zero_cnt), 32'd255);
        apply_stimulus(1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
        check_output("zc.hold",        32'(bus.zero_cnt), 32'd255);
        apply_stimulus(1'b1, 32'h0, 1'b1, 1'b1, 1'b1);
        check_output("zc.clr_wins",    32'(bus.zero_cnt), 32'h0);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset between edges with two entries stored.
        apply_stimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("arst.out_valid", 32'(bus.out_valid), 32'h0);
        check_output("arst.in_ready",  32'(bus.in_ready),  32'h1);
        check_output("arst.zero_cnt",  32'(bus.zero_cnt),  32'h0);
        check_output("arst.flag_err",  32'(bus.flag_err),  32'h0);
        check_output("arst.out_result", bus.out_result,    32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_output("arst.no_stale",  32'(bus.out_valid), 32'h0);

        for (int i = 0; i < 600; i++) begin
            logic [WIDTH-1:0] r;
            bit z;
            r = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom());
            z = (r == 0);
            if ($urandom_range(0, 39) == 0) z = ~z;
            apply_stimulus($urandom_range(0, 9) < 7, r, z,
                           $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end
        repeat (3) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
